sipo_frame_rx: RTL and testbench
================================

Name: sipo_frame_rx

Overview:
Serial-to-parallel front end for the ballot-key path. It deframes a bit-serial key code (start bit, DATA_W data bits LSB first, optional even parity, stop bit) into a parallel word. It then issues a one-cycle load strobe that drives the downstream PIPO holding register (word_out -> pipo_in, load -> load). It also flags framing, parity and stall errors to the control FSM.

Parameters:
DATA_W, 4, data bits per frame; equals PIPO width.
PARITY_EN, 1, 1 = even parity bit follows data; 0 = no parity bit.
TIMEOUT, 16, consecutive cycles without serial_valid mid-frame before abort; 0 disables; counter width $clog2(TIMEOUT+1).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
serial_in  input  1  serial line; idle level 1.
serial_valid  input  1  bit strobe; serial_in is sampled only on edges where this is 1.
word_out  output  DATA_W  last correctly received word; held between frames.
load  output  1  one-cycle pulse, high in the cycle word_out takes a new value.
parity_err  output  1  one-cycle pulse on parity mismatch.
frame_err  output  1  one-cycle pulse on bad stop bit or timeout.
busy  output  1  high while state != IDLE.

Behaviour:
- Reset (reset=0, async): state IDLE, word_out=0, load=0, parity_err=0, frame_err=0, busy=0, bit counter=0, timeout counter=0, shift register=0. Reset mid-frame discards the partial frame and generates no pulses.
- All outputs are registered. Pulses are high exactly one cycle, in the cycle after the edge that samples the deciding bit.
- States: IDLE, DATA, PARITY, STOP.
- IDLE: on serial_valid=1 and serial_in=0, go to DATA with bit counter 0. serial_in=1 and serial_valid=0 are ignored.
- DATA: each valid bit shifts into bit position counter (LSB first). After the DATA_W-th bit, go to PARITY if PARITY_EN=1, else go to STOP.
- PARITY: the valid bit is latched as p_bit. Parity is OK when p_bit == XOR of the data bits. Then go to STOP.
- STOP, sampling a valid bit:
  - serial_in=1 and parity OK (or PARITY_EN=0): word_out <= shift register, load=1, go to IDLE.
  - serial_in=1 and parity bad: parity_err=1, word_out unchanged, no load, go to IDLE.
  - serial_in=0: frame_err=1, word_out unchanged, no load, go to IDLE. This holds regardless of parity; parity_err stays 0.
  - The stop bit is not also treated as a new start bit.
- Back-to-back frames: a start bit on the first valid edge after STOP is accepted. The minimum frame period is DATA_W+2+PARITY_EN valid cycles. Back-to-back load pulses are separated by at least that many cycles.
- Timeout (TIMEOUT>0):
  - In a non-IDLE state, the counter increments on each edge with serial_valid=0 and clears on any edge with serial_valid=1.
  - On the edge where the counter equals TIMEOUT-1 and serial_valid=0: frame_err=1, go to IDLE, counter cleared, word_out unchanged.
  - In IDLE the counter is held at 0.
- busy is high from the cycle after the start bit is sampled until the cycle after the stop bit or timeout edge.
- load, parity_err and frame_err are mutually exclusive in any cycle.

Test Plan:
1. Good frame, DATA_W=4, PARITY_EN=1, one valid bit per cycle: 0,1,0,0,1,0,1 (start, data 1001 LSB first, parity 0, stop) -> load high for 1 cycle, word_out=4'b1001 held afterwards, both error flags 0, busy for 6 cycles.
2. Parity error after case 1: frame for 4'b1011 with parity bit 0 (correct value is 1) -> parity_err pulse, no load, word_out stays 4'b1001.
3. Framing error: frame for 4'b0001 with correct parity 1 but stop bit 0 -> frame_err pulse only, parity_err=0, word_out unchanged, state returns to IDLE.
4. Timeout: start bit plus 2 data bits, then serial_valid=0 for 16 cycles -> frame_err pulse after the 16th idle edge, busy drops. A following good 4'b1111 frame loads normally.
5. Reset mid-frame: reset=0 after 3 data bits -> all outputs 0 immediately (async), no pulses. A good 4'b1010 frame after release loads 4'b1010.
6. Back-to-back plus gaps: 4'b0110 then 4'b1111 with no idle between, serial_valid toggling 1/0 -> two load pulses, word_out 4'b0110 then 4'b1111; serial_in is ignored when serial_valid=0.

Source files
------------

// File: rtl/sipo_frame_rx.sv
// Serial-to-parallel key-code receiver.
// Deframes start / DATA_W data bits (LSB first) / optional even parity / stop,
// presents the last good word and pulses load, parity_err or frame_err for
// exactly one cycle once the deciding bit has been sampled.
module sipo_frame_rx #(
    parameter int DATA_W    = 4,
    parameter int PARITY_EN = 1,
    parameter int TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              serial_in,
    input  logic              serial_valid,
    output logic [DATA_W-1:0] word_out,
    output logic              load,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                par_ok_q, par_ok_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic                load_q, load_d;
    logic                perr_q, perr_d;
    logic                ferr_q, ferr_d;
    logic                busy_q, busy_d;
    logic                timed_out;

    // Next-state, datapath and registered-output decode for the deframer.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        to_cnt_d  = to_cnt_q;
        shift_d   = shift_q;
        par_ok_d  = par_ok_q;
        word_d    = word_q;
        load_d    = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;

        // Abort a stalled frame on the edge that would reach TIMEOUT idle cycles.
        timed_out = (TIMEOUT > 0) && (state_q != IDLE) && !serial_valid
                    && (to_cnt_q == TO_LAST);

        // Stall counter only runs mid-frame and restarts on every valid bit.
        if ((TIMEOUT == 0) || (state_q == IDLE) || serial_valid) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end

        if (timed_out) begin
            ferr_d    = 1'b1;
            state_d   = IDLE;
            to_cnt_d  = '0;
            bit_cnt_d = '0;
        end else if (serial_valid) begin
            case (state_q)
                IDLE: begin
                    if (!serial_in) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                    end
                end
                DATA: begin
                    shift_d[bit_cnt_q] = serial_in;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        // Without a parity bit the frame is treated as parity-clean.
                        par_ok_d  = 1'b1;
                        state_d   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
                PARITY: begin
                    par_ok_d = (serial_in == ^shift_q);
                    state_d  = STOP;
                end
                STOP: begin
                    // A bad stop bit wins over a parity mismatch.
                    state_d = IDLE;
                    if (!serial_in) begin
                        ferr_d = 1'b1;
                    end else if (!par_ok_q) begin
                        perr_d = 1'b1;
                    end else begin
                        word_d = shift_q;
                        load_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset drops any partial frame silently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            to_cnt_q  <= '0;
            shift_q   <= '0;
            par_ok_q  <= 1'b0;
            word_q    <= '0;
            load_q    <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            to_cnt_q  <= to_cnt_d;
            shift_q   <= shift_d;
            par_ok_q  <= par_ok_d;
            word_q    <= word_d;
            load_q    <= load_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
        end
    end

    assign word_out   = word_q;
    assign load       = load_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Bench for sipo_frame_rx: directed frames plus random frames, each outcome
// predicted at frame level (data, parity bit, stop bit) rather than per state.
module tb_sipo_frame_rx;

    localparam int DATA_W    = 4;
    localparam int PARITY_EN = 1;
    localparam int TIMEOUT   = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              serial_in = 1'b1;
    logic              serial_valid = 1'b0;
    logic [DATA_W-1:0] word_out;
    logic              load;
    logic              parity_err;
    logic              frame_err;
    logic              busy;

    sipo_frame_rx #(
        .DATA_W   (DATA_W),
        .PARITY_EN(PARITY_EN),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .serial_in   (serial_in),
        .serial_valid(serial_valid),
        .word_out    (word_out),
        .load        (load),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Expected frame outcome, checked in the cycle after the deciding edge.
    logic [DATA_W-1:0] exp_word = '0;
    logic              exp_load = 1'b0;
    logic              exp_perr = 1'b0;
    logic              exp_ferr = 1'b0;
    logic              pend = 1'b0;
    int                stray = 0;
    logic              seen_busy = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus. Outputs are sampled at the falling edge before
    // the new inputs are applied; a pending frame result is checked here,
    // otherwise any pulse at all is unexpected.
    task automatic drive_cycle(input logic v, input logic b);
        @(negedge clk);
        seen_busy = busy;
        if (pend) begin
            check("load", load, exp_load);
            check("parity_err", parity_err, exp_perr);
            check("frame_err", frame_err, exp_ferr);
            check("word_out", word_out, exp_word);
            check("busy_end", busy, 0);
            check("stray_pulses", stray, 0);
            $display("frame result: word=%h load=%b perr=%b ferr=%b", word_out, load, parity_err, frame_err);
            pend = 1'b0;
        end else if (load || parity_err || frame_err) begin
            stray++;
        end
        serial_valid = v;
        serial_in    = b;
    endtask

    // Invalid cycles with junk on serial_in: 0 none, 1 exactly one, 2 random 0..3.
    task automatic gap(input int mode);
        int n;
        n = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 3));
        repeat (n) drive_cycle(1'b0, 1'($urandom_range(0, 1)));
    endtask

    task automatic build_bits(input logic [DATA_W-1:0] d, input logic pb, input logic sb,
                              output logic bits[$]);
        bits = {};
        bits.push_back(1'b0);
        for (int i = 0; i < DATA_W; i++) bits.push_back(d[i]);
        if (PARITY_EN != 0) bits.push_back(pb);
        bits.push_back(sb);
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] d, input logic pb, input logic sb,
                              input int mode);
        logic bits[$];
        logic par_good;
        build_bits(d, pb, sb, bits);
        foreach (bits[i]) begin
            gap(mode);
            drive_cycle(1'b1, bits[i]);
            if (i == 1) check("busy_mid", seen_busy, 1);
        end
        par_good = (PARITY_EN == 0) || (pb == ^d);
        exp_ferr = !sb;
        exp_perr = sb && !par_good;
        exp_load = sb && par_good;
        if (exp_load) exp_word = d;
        pend = 1'b1;
    endtask

    // Send the first m bits of a frame, then stall for TIMEOUT invalid cycles.
    task automatic send_stall(input logic [DATA_W-1:0] d, input int m);
        logic bits[$];
        build_bits(d, ^d, 1'b1, bits);
        for (int i = 0; i < m; i++) drive_cycle(1'b1, bits[i]);
        repeat (TIMEOUT) drive_cycle(1'b0, 1'($urandom_range(0, 1)));
        exp_ferr = 1'b1;
        exp_perr = 1'b0;
        exp_load = 1'b0;
        pend     = 1'b1;
    endtask

    initial begin
        logic [DATA_W-1:0] d;
        logic pb, sb;
        int sel;

        // Reset held: a start bit offered now must be ignored.
        serial_valid = 1'b1;
        serial_in    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_word", word_out, 0);
        check("rst_load", load, 0);
        check("rst_perr", parity_err, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_busy", busy, 0);
        serial_valid = 1'b0;
        serial_in    = 1'b1;
        reset        = 1'b1;

        // Good frame 1001, parity 0.
        send_frame(4'b1001, 1'b0, 1'b1, 0);
        drive_cycle(1'b0, 1'b1);
        // Parity error: 1011 needs parity 1.
        send_frame(4'b1011, 1'b0, 1'b1, 0);
        drive_cycle(1'b0, 1'b1);
        // Framing error with correct parity.
        send_frame(4'b0001, 1'b1, 1'b0, 0);
        drive_cycle(1'b0, 1'b1);
        // Stall after start plus two data bits, then a good frame.
        send_stall(4'b0110, 3);
        send_frame(4'b1111, 1'b0, 1'b1, 0);
        drive_cycle(1'b0, 1'b1);

        // Asynchronous reset after three data bits.
        drive_cycle(1'b1, 1'b0);
        drive_cycle(1'b1, 1'b1);
        drive_cycle(1'b1, 1'b0);
        drive_cycle(1'b1, 1'b1);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("midrst_word", word_out, 0);
        check("midrst_load", load, 0);
        check("midrst_perr", parity_err, 0);
        check("midrst_ferr", frame_err, 0);
        check("midrst_busy", busy, 0);
        exp_word = '0;
        @(negedge clk);
        serial_valid = 1'b0;
        serial_in    = 1'b1;
        reset        = 1'b1;
        send_frame(4'b1010, 1'b0, 1'b1, 0);

        // Back-to-back with toggling valid, then strictly back-to-back.
        send_frame(4'b0110, 1'b0, 1'b1, 1);
        send_frame(4'b1111, 1'b0, 1'b1, 1);
        send_frame(4'b0011, 1'b0, 1'b1, 0);
        send_frame(4'b0100, 1'b1, 1'b1, 0);

        // Random frames, stalls and idle chatter.
        for (int n = 0; n < 60; n++) begin
            repeat ($urandom_range(0, 2)) drive_cycle(1'($urandom_range(0, 1)), 1'b1);
            d   = DATA_W'($urandom);
            sel = int'($urandom_range(0, 9));
            if (sel == 0) begin
                send_stall(d, int'($urandom_range(1, DATA_W + PARITY_EN + 1)));
            end else begin
                pb = (^d) ^ ($urandom_range(0, 3) == 0);
                sb = ($urandom_range(0, 3) != 0);
                send_frame(d, pb, sb, 2);
            end
        end
        drive_cycle(1'b0, 1'b1);
        drive_cycle(1'b0, 1'b1);
        check("final_stray", stray, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
